// File: rtl/stream_width_packer.sv
// Byte-stream repacker: variable-fill IN_BYTES beats in, dense OUT_BYTES beats out.
// Fully registered, packet-isolating width converter.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   in_data/in_cnt  input bytes (byte 0 in [7:0]) and valid count (0 means IN_BYTES)
//   in_last         final beat of packet
//   in_valid/ready  input handshake
//   out_data        packed output bytes (byte 0 in [7:0])
//   out_cnt         valid bytes on the last beat (0 means full), 0 on other beats
//   out_last        final beat of packet
//   out_valid/ready output handshake
//   fill_level      bytes currently buffered
module stream_width_packer #(
    parameter int IN_BYTES  = 8,
    parameter int OUT_BYTES = 8
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic [IN_BYTES*8-1:0]                     in_data,
    input  logic [$clog2(IN_BYTES)-1:0]               in_cnt,
    input  logic                                      in_last,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    output logic [OUT_BYTES*8-1:0]                    out_data,
    output logic [$clog2(OUT_BYTES)-1:0]              out_cnt,
    output logic                                      out_last,
    output logic                                      out_valid,
    input  logic                                      out_ready,
    output logic [$clog2(IN_BYTES+OUT_BYTES):0]       fill_level
);

    localparam int BUF_BYTES = IN_BYTES + OUT_BYTES;
    localparam int IW        = $clog2(IN_BYTES);
    localparam int OW        = $clog2(OUT_BYTES);
    localparam int BW        = $clog2(BUF_BYTES);
    localparam int FW        = BW + 1;

    logic [7:0]    buf_q [BUF_BYTES];
    logic [7:0]    buf_d [BUF_BYTES];
    logic [7:0]    in_b  [IN_BYTES];
    logic [FW-1:0] fill_q, fill_d;
    logic          eop_q, eop_d;
    logic [FW-1:0] pop, push, keep;
    logic [FW-1:0] src, off;
    logic          in_fire, out_fire;

    for (genvar j = 0; j < IN_BYTES; j++) begin : g_in_b
        assign in_b[j] = in_data[j*8 +: 8];
    end

    for (genvar j = 0; j < OUT_BYTES; j++) begin : g_out_b
        assign out_data[j*8 +: 8] = buf_q[j];
    end

    // fill + IN_BYTES <= BUF_BYTES reduces to fill <= OUT_BYTES
    assign in_ready   = rst_n && !eop_q && (fill_q <= FW'(OUT_BYTES));
    assign out_valid  = rst_n && ((fill_q >= FW'(OUT_BYTES)) ||
                                  (eop_q && fill_q != '0));
    assign out_last   = eop_q && (fill_q <= FW'(OUT_BYTES));
    assign out_cnt    = out_last ? fill_q[OW-1:0] : '0;
    assign fill_level = fill_q;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    assign pop  = !out_fire ? '0 :
                  (fill_q < FW'(OUT_BYTES)) ? fill_q : FW'(OUT_BYTES);
    assign push = !in_fire ? '0 :
                  (in_cnt == '0) ? FW'(IN_BYTES) : FW'(in_cnt);
    assign keep   = fill_q - pop;
    assign fill_d = keep + push;

    // in_fire needs !eop_q and out_last needs eop_q, so set and clear never collide
    always_comb begin
        eop_d = eop_q;
        if (in_fire && in_last) begin
            eop_d = 1'b1;
        end else if (out_fire && out_last) begin
            eop_d = 1'b0;
        end
    end

    // Surviving bytes shift down by pop; new bytes land right behind them
    always_comb begin
        src = '0;
        off = '0;
        for (int i = 0; i < BUF_BYTES; i++) begin
            buf_d[i] = buf_q[i];
            if (FW'(i) < keep) begin
                src      = FW'(i) + pop;
                buf_d[i] = buf_q[src[BW-1:0]];
            end else if (FW'(i) - keep < push) begin
                off      = FW'(i) - keep;
                buf_d[i] = in_b[off[IW-1:0]];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fill_q <= '0;
            eop_q  <= 1'b0;
        end else begin
            fill_q <= fill_d;
            eop_q  <= eop_d;
        end
    end

    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (fill_q <= FW'(BUF_BYTES));
            assert (!out_last || fill_q != '0);
        end
    end
`endif

endmodule

// File: tb/tb_stream_width_packer.sv
// Self-checking bench for stream_width_packer across (IN,OUT) in {4,8}^2.
// Byte-queue scoreboard, directed table, corner sequences, random stress.
module tb_stream_width_packer;

    localparam int NC = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] in_data   [NC];
    logic [2:0]  in_cnt    [NC];
    logic        in_last   [NC];
    logic        in_valid  [NC];
    logic        in_ready  [NC];
    logic [63:0] out_data  [NC];
    logic [2:0]  out_cnt   [NC];
    logic        out_last  [NC];
    logic        out_valid [NC];
    logic        out_ready [NC];
    logic [4:0]  fill_level[NC];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NC; g++) begin : g_dut
        localparam int IB = (g >= 2) ? 8 : 4;
        localparam int OB = (g % 2 == 1) ? 8 : 4;
        localparam int IW = $clog2(IB);
        localparam int OW = $clog2(OB);
        localparam int FW = $clog2(IB + OB) + 1;
        logic [OB*8-1:0] od;
        logic [OW-1:0]   oc;
        logic [FW-1:0]   fl;
        logic            ir, ol, ov;
        stream_width_packer #(.IN_BYTES(IB), .OUT_BYTES(OB)) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .in_data    (in_data[g][IB*8-1:0]),
            .in_cnt     (in_cnt[g][IW-1:0]),
            .in_last    (in_last[g]),
            .in_valid   (in_valid[g]),
            .in_ready   (ir),
            .out_data   (od),
            .out_cnt    (oc),
            .out_last   (ol),
            .out_valid  (ov),
            .out_ready  (out_ready[g]),
            .fill_level (fl)
        );
        assign out_data[g]   = 64'(od);
        assign out_cnt[g]    = 3'(oc);
        assign fill_level[g] = 5'(fl);
        assign in_ready[g]   = ir;
        assign out_last[g]   = ol;
        assign out_valid[g]  = ov;
    end

    typedef struct {
        logic [7:0] b;
        bit         eop;
    } sb_t;

    typedef struct packed {
        int              c;
        int              n_in;
        logic [4:0][3:0] cnt;
        int              n_out;
        int              lcnt;
    } vec_t;

    sb_t sb[$];
    bit  pend;
    int  seq;
    int  out_beats;
    int  last_cnt;
    int  nchecks;
    int  nfail;

    function automatic int ibytes(int c);
        return (c >= 2) ? 8 : 4;
    endfunction

    function automatic int obytes(int c);
        return (c % 2 == 1) ? 8 : 4;
    endfunction

    function automatic vec_t mk(int c, int n_in, int a0, int a1, int a2,
                                int a3, int a4, int n_out, int lcnt);
        vec_t v;
        v.c      = c;
        v.n_in   = n_in;
        v.cnt[0] = 4'(a0);
        v.cnt[1] = 4'(a1);
        v.cnt[2] = 4'(a2);
        v.cnt[3] = 4'(a3);
        v.cnt[4] = 4'(a4);
        v.n_out  = n_out;
        v.lcnt   = lcnt;
        return v;
    endfunction

    task automatic chk(bit ok, string nm, longint act, longint exp);
        nchecks++;
        if (!ok) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called at a falling edge: drive one cycle, check against the model,
    // update the model with the handshakes of the coming rising edge.
    task automatic step(int c, bit iv, int n, bit il, bit ordy, output bit acc);
        int  ib, ob, no, sz;
        bit  ok_d, ok_f, exp_ov;
        int  ab, eb;
        sb_t e;
        ib  = ibytes(c);
        ob  = obytes(c);
        acc = 1'b0;
        in_valid[c]  = iv;
        in_last[c]   = il;
        in_cnt[c]    = 3'(n % ib);
        out_ready[c] = ordy;
        for (int k = 0; k < 8; k++) begin
            in_data[c][k*8 +: 8] = (k < n) ? 8'(seq + k) : 8'($urandom);
        end
        #1;
        sz     = sb.size();
        exp_ov = (sz >= ob) || (pend && sz > 0);
        chk(int'(fill_level[c]) == sz, "fill_level", fill_level[c], sz);
        chk(in_ready[c] == (!pend && sz <= ob), "in_ready",
            in_ready[c], (!pend && sz <= ob));
        chk(out_valid[c] == exp_ov, "out_valid", out_valid[c], exp_ov);
        if (out_valid[c]) begin
            chk(out_last[c] == (pend && sz <= ob), "out_last",
                out_last[c], (pend && sz <= ob));
        end
        if (out_valid[c] && ordy) begin
            if (out_last[c]) begin
                no = (out_cnt[c] == 0) ? ob : int'(out_cnt[c]);
            end else begin
                no = ob;
                chk(out_cnt[c] == 0, "out_cnt_mid", out_cnt[c], 0);
            end
            ok_d = 1'b1;
            ok_f = 1'b1;
            ab   = 0;
            eb   = 0;
            for (int k = 0; k < no; k++) begin
                if (sb.size() == 0) begin
                    ok_f = 1'b0;
                    break;
                end
                e = sb.pop_front();
                if (out_data[c][k*8 +: 8] != e.b && ok_d) begin
                    ok_d = 1'b0;
                    ab   = int'(out_data[c][k*8 +: 8]);
                    eb   = int'(e.b);
                end
                if (e.eop != (out_last[c] && k == no - 1)) ok_f = 1'b0;
            end
            chk(ok_d, "out_data", ab, eb);
            chk(ok_f, "framing", no, sz);
            out_beats++;
            if (out_last[c]) begin
                pend     = 1'b0;
                last_cnt = int'(out_cnt[c]);
            end
        end
        if (iv && in_ready[c]) begin
            for (int k = 0; k < n; k++) begin
                sb.push_back('{b: 8'(seq + k), eop: (il && k == n - 1)});
            end
            seq  = seq + n;
            pend = pend | il;
            acc  = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic send(int c, int n, bit il);
        bit acc;
        int t;
        acc = 1'b0;
        t   = 0;
        while (!acc && t < 40) begin
            step(c, 1'b1, n, il, 1'b1, acc);
            t++;
        end
        chk(acc, "accept_timeout", t, 40);
    endtask

    task automatic drain(int c);
        bit acc;
        int t;
        t = 0;
        while ((sb.size() != 0 || pend) && t < 100) begin
            step(c, 1'b0, 1, 1'b0, 1'b1, acc);
            t++;
        end
        chk(sb.size() == 0 && !pend, "drain", sb.size(), 0);
    endtask

    initial begin
        vec_t vt[6];
        bit   acc;
        int   na, ib;

        nchecks = 0;
        nfail   = 0;
        seq     = 0;
        pend    = 1'b0;
        for (int c = 0; c < NC; c++) begin
            in_data[c]   = '0;
            in_cnt[c]    = '0;
            in_last[c]   = 1'b0;
            in_valid[c]  = 1'b0;
            out_ready[c] = 1'b0;
        end

        vt[0] = mk(3, 2, 3, 5, 0, 0, 0, 1, 0);
        vt[1] = mk(1, 5, 4, 4, 4, 4, 4, 3, 4);
        vt[2] = mk(2, 1, 8, 0, 0, 0, 0, 2, 0);
        vt[3] = mk(0, 3, 1, 2, 3, 0, 0, 2, 2);
        vt[4] = mk(3, 1, 1, 0, 0, 0, 0, 1, 1);
        vt[5] = mk(2, 2, 8, 3, 0, 0, 0, 3, 3);

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk(out_valid[c] == 1'b0 && out_last[c] == 1'b0, "rst_out", out_valid[c], 0);
            chk(out_cnt[c] == 0 && fill_level[c] == 0, "rst_fill", fill_level[c], 0);
            chk(in_ready[c] == 1'b1, "rst_in_ready", in_ready[c], 1);
        end
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            out_beats = 0;
            last_cnt  = -1;
            for (int b = 0; b < vt[i].n_in; b++) begin
                send(vt[i].c, int'(vt[i].cnt[b]), b == vt[i].n_in - 1);
            end
            drain(vt[i].c);
            chk(out_beats == vt[i].n_out, "vec_beats", out_beats, vt[i].n_out);
            chk(last_cnt == vt[i].lcnt, "vec_last_cnt", last_cnt, vt[i].lcnt);
        end

        // backpressure fills the buffer to capacity
        out_beats = 0;
        na = 0;
        for (int k = 0; k < 10; k++) begin
            step(3, 1'b1, 8, 1'b0, 1'b0, acc);
            na += int'(acc);
        end
        chk(na == 2, "bp_accepted", na, 2);
        chk(fill_level[3] == 5'd16, "bp_fill", fill_level[3], 16);
        chk(in_ready[3] == 1'b0, "bp_in_ready", in_ready[3], 0);
        send(3, 8, 1'b1);
        drain(3);
        chk(out_beats == 3, "bp_beats", out_beats, 3);

        // next packet is held off until the previous out_last handshake
        send(3, 2, 1'b1);
        chk(out_valid[3] && out_last[3] && out_cnt[3] == 3'd2 && !in_ready[3],
            "pkt_a_last", out_cnt[3], 2);
        step(3, 1'b1, 8, 1'b1, 1'b1, acc);
        chk(!acc, "pkt_b_held", acc, 0);
        step(3, 1'b1, 8, 1'b1, 1'b1, acc);
        chk(acc, "pkt_b_accept", acc, 1);
        drain(3);

        // reset in the middle of a packet
        step(3, 1'b1, 5, 1'b0, 1'b0, acc);
        chk(fill_level[3] == 5'd5, "mid_fill", fill_level[3], 5);
        rst_n       = 1'b0;
        in_valid[3] = 1'b0;
        #1;
        chk(!in_ready[3] && !out_valid[3], "in_rst_0", in_ready[3], 0);
        @(negedge clk);
        #1;
        chk(!in_ready[3] && !out_valid[3], "in_rst_1", out_valid[3], 0);
        rst_n = 1'b1;
        sb.delete();
        pend = 1'b0;
        #1;
        chk(fill_level[3] == 0 && in_ready[3] && !out_valid[3],
            "post_rst", fill_level[3], 0);
        @(negedge clk);
        send(3, 3, 1'b1);
        drain(3);

        for (int c = 0; c < NC; c++) begin
            ib = ibytes(c);
            for (int k = 0; k < 300; k++) begin
                step(c, $urandom_range(0, 3) != 0, $urandom_range(1, ib),
                     $urandom_range(0, 4) == 0, $urandom_range(0, 3) != 0, acc);
            end
            send(c, 1, 1'b1);
            drain(c);
        end

        $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
        $finish;
    end

endmodule
